fp_expander: RTL and testbench



---
 rtl/fp_expander_if.sv | 24 ++
 rtl/fp_expander.sv | 96 +++++++++
 tb/tb_fp_expander.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_expander_if.sv
// Handshake bus for fp_expander: {s, e, f} input channel and d output channel.
interface fp_expander_if;
   logic        in_valid;
   logic        in_ready;
   logic        s;
   logic [2:0]  e;
   logic [3:0]  f;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] d;
   logic        busy;

   // Upstream/downstream side (drives inputs, observes results)
   modport master (
      output in_valid, s, e, f, out_ready,
      input  in_ready, out_valid, d, busy
   );

   // Converter side
   modport slave (
      input  in_valid, s, e, f, out_ready,
      output in_ready, out_valid, d, busy
   );
endinterface

// File: rtl/fp_expander.sv
// Sequential expander: {s, e[2:0], f[3:0]} -> 12-bit two's-complement (-1)^s * f * 2^e,
// one shift per cycle behind valid/ready handshakes.
module fp_expander (
   input  logic          clk,
   input  logic          rst_n,
   fp_expander_if.slave  bus
);

   localparam int unsigned D_W = 12;
   localparam int unsigned E_W = 3;
   localparam int unsigned F_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_OUT   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [E_W-1:0]   cnt_q, cnt_d;
   logic [D_W-1:0]   mag_q, mag_d;
   logic             sgn_q, sgn_d;
   logic [D_W-1:0]   d_q, d_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mag_d   = mag_q;
      sgn_d   = sgn_q;
      d_d     = d_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               sgn_d   = bus.s;
               cnt_d   = bus.e;
               mag_d   = {(D_W - F_W)'(0), bus.f};
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               mag_d = mag_q << 1;
               cnt_d = cnt_q - E_W'(1);
            end else begin
               // Negate for negative sign; -0 naturally yields 0
               d_d     = sgn_q ? (~mag_q + D_W'(1)) : mag_q;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (bus.out_ready && out_valid_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_OUT);
      busy_d      = (state_d != ST_IDLE);
   end

   // State and output registers; reset discards any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mag_q       <= '0;
         sgn_q       <= 1'b0;
         d_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mag_q       <= mag_d;
         sgn_q       <= sgn_d;
         d_q         <= d_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.d         = d_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp_expander.sv
// Self-checking bench for fp_expander: directed vector table, hand-written reset/immunity
// sequences, and an exhaustive round trip against an arithmetic reference.
module tb_fp_expander;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   fp_expander_if bus ();

   fp_expander dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [2:0]  e;
      logic [3:0]  f;
      int          hold;
      logic [11:0] exp_d;
   } vec_t;

   // Reference: signed product f * 2^e, wrapped to 12 bits
   function automatic logic [11:0] ref_d(input logic s, input int e, input int f);
      int v;
      v = f * (2 ** e);
      if (s) v = -v;
      return 12'(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction. hold = cycles of out_ready low after out_valid rises.
   // scramble = keep in_valid high with changing data while busy.
   task automatic do_txn(input logic s, input logic [2:0] e, input logic [3:0] f,
                         input int hold, input logic [11:0] exp_d, input bit scramble,
                         input bit rand_ready);
      int          lat;
      bit          ok;
      logic [11:0] d0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) chk("in_ready_wait_timeout", 0, 1);
      bus.in_valid = 1'b1;
      bus.s = s;
      bus.e = e;
      bus.f = f;
      step();
      if (scramble) begin
         bus.s = 1'($urandom);
         bus.e = 3'($urandom);
         bus.f = 4'($urandom);
      end else begin
         bus.in_valid = 1'b0;
      end
      chk("in_ready_after_accept", int'(bus.in_ready), 0);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rand_ready) bus.out_ready = 1'($urandom);
         else bus.out_ready = 1'b0;
         step();
         lat++;
         if (scramble) begin
            bus.s = 1'($urandom);
            bus.e = 3'($urandom);
            bus.f = 4'($urandom);
         end
         if (bus.out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (bus.busy !== 1'b1) chk("busy_during_shift", int'(bus.busy), 1);
      end
      if (!ok) chk("out_valid_timeout", 0, 1);
      chk("latency", lat, int'(e) + 1);
      chk("d_value", int'(bus.d), int'(exp_d));
      d0 = bus.d;
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         if (scramble) begin
            bus.s = 1'($urandom);
            bus.e = 3'($urandom);
            bus.f = 4'($urandom);
         end
         if (bus.out_valid !== 1'b1 || bus.d !== d0 || bus.in_ready !== 1'b0) begin
            chk("backpressure_hold", int'({bus.out_valid, bus.in_ready, bus.d}),
                int'({1'b1, 1'b0, d0}));
         end else begin
            checks++;
         end
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("in_ready_after_handshake", int'(bus.in_ready), 1);
      chk("out_valid_after_handshake", int'(bus.out_valid), 0);
   endtask

   vec_t vecs[6];

   initial begin
      checks = 0;
      errors = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.s = 1'b0;
      bus.e = 3'd0;
      bus.f = 4'd0;
      rst_n = 1'b0;
      #12;
      chk("reset_in_ready", int'(bus.in_ready), 1);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_d", int'(bus.d), 0);
      rst_n = 1'b1;
      step();

      vecs[0] = '{s: 1'b0, e: 3'd7, f: 4'd15, hold: 0,  exp_d: 12'h780};
      vecs[1] = '{s: 1'b1, e: 3'd7, f: 4'd15, hold: 0,  exp_d: 12'h880};
      vecs[2] = '{s: 1'b1, e: 3'd0, f: 4'd5,  hold: 0,  exp_d: 12'hFFB};
      vecs[3] = '{s: 1'b1, e: 3'd3, f: 4'd0,  hold: 0,  exp_d: 12'h000};
      vecs[4] = '{s: 1'b0, e: 3'd2, f: 4'd3,  hold: 10, exp_d: 12'h00C};
      vecs[5] = '{s: 1'b0, e: 3'd4, f: 4'd10, hold: 2,  exp_d: 12'h0A0};
      foreach (vecs[i]) begin
         do_txn(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].hold, vecs[i].exp_d, 1'b0, 1'b0);
      end

      // Reset asserted two cycles into a shift
      bus.in_valid = 1'b1;
      bus.s = 1'b0;
      bus.e = 3'd5;
      bus.f = 4'd9;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("midshift_rst_out_valid", int'(bus.out_valid), 0);
      chk("midshift_rst_d", int'(bus.d), 0);
      chk("midshift_rst_in_ready", int'(bus.in_ready), 1);
      chk("midshift_rst_busy", int'(bus.busy), 0);
      #2;
      rst_n = 1'b1;
      step();
      do_txn(1'b0, 3'd0, 4'd1, 0, 12'h001, 1'b0, 1'b0);

      // Input changes while busy must be ignored
      for (int i = 0; i < 8; i++) begin
         logic       s;
         logic [2:0] e;
         logic [3:0] f;
         s = 1'($urandom);
         e = 3'($urandom);
         f = 4'($urandom);
         do_txn(s, e, f, int'($urandom_range(0, 3)), ref_d(s, int'(e), int'(f)), 1'b1, 1'b1);
      end

      // Exhaustive round trip with random output back-pressure
      for (int i = 0; i < 256; i++) begin
         logic [7:0] c;
         c = 8'(i);
         do_txn(c[7], c[6:4], c[3:0], int'($urandom_range(0, 2)),
                ref_d(c[7], int'(c[6:4]), int'(c[3:0])), 1'b0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
